// File: rtl/sdram_arbiter_if.sv
// Requester/SDRAM-controller signal bundle for the frame-buffer arbiter.
// slave = arbiter side, master = requesters plus memory controller side.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 24
);
   logic              i_wr_req;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [DATA_W-1:0] i_wr_data;
   logic              o_wr_pop;
   logic              o_wr_done;
   logic              i_rd_req;
   logic [ADDR_W-1:0] i_rd_addr;
   logic              o_rd_push;
   logic [DATA_W-1:0] o_rd_data;
   logic              o_rd_done;
   logic              o_mem_req;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              i_mem_ack;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              i_mem_wready;
   logic              i_mem_rvalid;
   logic [DATA_W-1:0] i_mem_rdata;
   logic              o_busy;

   modport slave (
      input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
             i_mem_ack, i_mem_wready, i_mem_rvalid, i_mem_rdata,
      output o_wr_pop, o_wr_done, o_rd_push, o_rd_data, o_rd_done,
             o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
   );

   modport master (
      output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
             i_mem_ack, i_mem_wready, i_mem_rvalid, i_mem_rdata,
      input  o_wr_pop, o_wr_done, o_rd_push, o_rd_data, o_rd_done,
             o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-client SDRAM burst arbiter: capture writes vs. VGA reads, read priority
// with a bounded number of read grants allowed to starve a waiting write.
module sdram_arbiter #(
   parameter int ADDR_W    = 23,
   parameter int DATA_W    = 24,
   parameter int BURST_LEN = 8,
   parameter int MAX_SKIP  = 3
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   sdram_arbiter_if.slave bus
);
   localparam int BW  = $clog2(BURST_LEN) + 1;
   localparam int SKW = (MAX_SKIP < 2) ? 1 : $clog2(MAX_SKIP + 1);

   typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_DATA, DONE} state_t;

   state_t            state_q, state_d;
   logic [SKW-1:0]    skip_q, skip_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              armed_q, armed_d;
   logic              grant_wr;
   logic [DATA_W-1:0] wdata, rdata;

   // Pixel words pass straight through; the arbiter never buffers data.
   assign wdata           = bus.i_wr_data;
   assign rdata           = bus.i_mem_rdata;
   assign bus.o_mem_wdata = wdata;
   assign bus.o_rd_data   = rdata;
   assign bus.o_mem_addr  = addr_q;
   assign bus.o_mem_we    = we_q;
   assign bus.o_busy      = (state_q != IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         skip_q  <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      skip_d        = skip_q;
      beat_d        = beat_q;
      addr_d        = addr_q;
      we_d          = we_q;
      // One dead cycle after reset release keeps the first command at least
      // two cycles away from the release edge.
      armed_d       = 1'b1;
      grant_wr      = 1'b0;
      bus.o_mem_req = 1'b0;
      bus.o_wr_pop  = 1'b0;
      bus.o_rd_push = 1'b0;
      bus.o_wr_done = 1'b0;
      bus.o_rd_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (armed_q && (bus.i_wr_req || bus.i_rd_req)) begin
               grant_wr = bus.i_wr_req &&
                          (!bus.i_rd_req || skip_q == SKW'(MAX_SKIP));
               we_d     = grant_wr;
               addr_d   = grant_wr ? bus.i_wr_addr : bus.i_rd_addr;
               if (grant_wr)
                  skip_d = '0;
               else if (bus.i_wr_req && skip_q != SKW'(MAX_SKIP))
                  skip_d = skip_q + SKW'(1);
               beat_d  = '0;
               state_d = CMD;
            end
         end
         CMD: begin
            bus.o_mem_req = 1'b1;
            if (bus.i_mem_ack)
               state_d = we_q ? WR_DATA : RD_DATA;
         end
         WR_DATA: begin
            bus.o_wr_pop = bus.i_mem_wready;
            if (bus.i_mem_wready) begin
               beat_d = beat_q + BW'(1);
               if (beat_d == BW'(BURST_LEN))
                  state_d = DONE;
            end
         end
         RD_DATA: begin
            bus.o_rd_push = bus.i_mem_rvalid;
            if (bus.i_mem_rvalid) begin
               beat_d = beat_q + BW'(1);
               if (beat_d == BW'(BURST_LEN))
                  state_d = DONE;
            end
         end
         DONE: begin
            bus.o_wr_done = we_q;
            bus.o_rd_done = !we_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboarded random bench for sdram_arbiter: a requester/memory model issues
// bursts and queues expected grants, data and done pulses; a monitor checks them.
module tb_sdram_arbiter;
   localparam int ADDR_W = 23, DATA_W = 24, BURST_LEN = 8, MAX_SKIP = 3;

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
                   .MAX_SKIP(MAX_SKIP)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

   typedef struct packed { logic we; logic [ADDR_W-1:0] addr; } grant_t;

   grant_t            grant_q[$];
   logic [DATA_W-1:0] wdata_q[$], rdata_q[$];
   logic              done_q[$];
   logic [ADDR_W-1:0] wq[$], rq[$];
   logic              seen_we[$];

   int checks = 0, errors = 0;
   int wr_pops = 0, rd_pushes = 0, wr_dones = 0, rd_dones = 0, req_cycles = 0;

   // model / driver configuration
   int phase = 0;        // 0 none, 1 waiting for command, 2 data, 3 done
   int ack_wait, ack_delay = 0, beats_left, model_skip = 0;
   int beat_pct = 100, stray_pct = 0, auto_left = 0;
   bit alt = 0, alt_tog = 0, garbage = 0, auto_ack = 0, drv_en = 0;
   logic cur_we = 1'b0;

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Grant rule: reads first unless the write has already been passed over
   // MAX_SKIP times; a lone request always wins.
   task automatic next_grant();
      grant_t g;
      if (wq.size() == 0 && rq.size() == 0) begin
         phase = 0;
         return;
      end
      if (wq.size() != 0 && (rq.size() == 0 || model_skip == MAX_SKIP)) begin
         g.we = 1'b1; g.addr = wq[0]; model_skip = 0;
      end else begin
         g.we = 1'b0; g.addr = rq[0];
         if (wq.size() != 0 && model_skip < MAX_SKIP) model_skip++;
      end
      cur_we = g.we;
      grant_q.push_back(g);
      if (auto_ack) ack_delay = $urandom_range(3);
      ack_wait = 0;
      phase = 1;
   endtask

   task automatic drive_reqs();
      bus.i_wr_req  = (wq.size() != 0);
      bus.i_wr_addr = (wq.size() != 0) ? wq[0] : '0;
      bus.i_rd_req  = (rq.size() != 0);
      bus.i_rd_addr = (rq.size() != 0) ? rq[0] : '0;
   endtask

   task automatic stray(input bit allow_w, input bit allow_r);
      if (allow_w && $urandom_range(99) < stray_pct) bus.i_mem_wready = 1'b1;
      if (allow_r && $urandom_range(99) < stray_pct) bus.i_mem_rvalid = 1'b1;
   endtask

   task automatic add_random();
      auto_left--;
      if ($urandom_range(1) == 1) wq.push_back(ADDR_W'($urandom));
      if ($urandom_range(1) == 1 || wq.size() == 0) rq.push_back(ADDR_W'($urandom));
   endtask

   // requester + memory-controller model, driven 1 ns after each rising edge
   initial forever begin
      bit beat;
      @(posedge i_clk);
      #1;
      if (i_rst_n && drv_en) begin
         bus.i_mem_ack    = 1'b0;
         bus.i_mem_wready = 1'b0;
         bus.i_mem_rvalid = 1'b0;
         bus.i_wr_data    = DATA_W'($urandom);
         bus.i_mem_rdata  = DATA_W'($urandom);
         case (phase)
            0: begin
               stray(1, 1);
               if (auto_left > 0 && wq.size() == 0 && rq.size() == 0) add_random();
               next_grant();
               drive_reqs();
            end
            1: begin
               stray(1, 1);
               if (bus.o_mem_req) begin
                  if (ack_wait >= ack_delay) begin
                     bus.i_mem_ack = 1'b1;
                     phase = 2; beats_left = BURST_LEN; alt_tog = 0;
                  end else ack_wait++;
               end
            end
            2: begin
               beat = alt ? alt_tog : ($urandom_range(99) < beat_pct);
               alt_tog = ~alt_tog;
               if (garbage) begin
                  bus.i_wr_req  = 1'($urandom);
                  bus.i_rd_req  = 1'($urandom);
                  bus.i_wr_addr = ADDR_W'($urandom);
                  bus.i_rd_addr = ADDR_W'($urandom);
               end
               stray(!cur_we, cur_we);
               if (beat) begin
                  if (cur_we) begin
                     bus.i_mem_wready = 1'b1;
                     wdata_q.push_back(bus.i_wr_data);
                  end else begin
                     bus.i_mem_rvalid = 1'b1;
                     rdata_q.push_back(bus.i_mem_rdata);
                  end
                  beats_left--;
                  if (beats_left == 0) phase = 3;
               end
            end
            default: begin
               stray(1, 1);
               done_q.push_back(cur_we);
               if (cur_we) void'(wq.pop_front()); else void'(rq.pop_front());
               if (auto_left > 0) add_random();
               next_grant();
               drive_reqs();
            end
         endcase
      end
   end

   // monitor / scoreboard, samples on the falling edge
   initial begin
      bit stall_hold = 0, hold_we = 0;
      logic [ADDR_W-1:0] hold_addr = '0;
      grant_t g;
      logic [DATA_W-1:0] d;
      logic e;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) stall_hold = 0;
         else begin
            if (bus.o_mem_req) req_cycles++;
            if (stall_hold) begin
               check(bus.o_mem_req, "stall_req", 32'(bus.o_mem_req), 1);
               check(bus.o_mem_addr == hold_addr, "stall_addr", 32'(bus.o_mem_addr), 32'(hold_addr));
               check(bus.o_mem_we == hold_we, "stall_we", 32'(bus.o_mem_we), 32'(hold_we));
            end
            stall_hold = bus.o_mem_req && !bus.i_mem_ack;
            hold_addr  = bus.o_mem_addr;
            hold_we    = bus.o_mem_we;
            if (bus.o_mem_req && bus.i_mem_ack) begin
               check(grant_q.size() != 0, "cmd_expected", 32'(grant_q.size()), 1);
               if (grant_q.size() != 0) begin
                  g = grant_q.pop_front();
                  check(bus.o_mem_we == g.we, "cmd_we", 32'(bus.o_mem_we), 32'(g.we));
                  check(bus.o_mem_addr == g.addr, "cmd_addr", 32'(bus.o_mem_addr), 32'(g.addr));
                  seen_we.push_back(bus.o_mem_we);
               end
            end
            if (bus.o_wr_pop) begin
               wr_pops++;
               check(wdata_q.size() != 0, "pop_expected", 32'(wdata_q.size()), 1);
               if (wdata_q.size() != 0) begin
                  d = wdata_q.pop_front();
                  check(bus.o_mem_wdata == d, "wdata", 32'(bus.o_mem_wdata), 32'(d));
               end
            end
            if (bus.o_rd_push) begin
               rd_pushes++;
               check(rdata_q.size() != 0, "push_expected", 32'(rdata_q.size()), 1);
               if (rdata_q.size() != 0) begin
                  d = rdata_q.pop_front();
                  check(bus.o_rd_data == d, "rdata", 32'(bus.o_rd_data), 32'(d));
               end
            end
            if (bus.o_wr_done || bus.o_rd_done) begin
               if (bus.o_wr_done) wr_dones++;
               if (bus.o_rd_done) rd_dones++;
               check(!(bus.o_wr_done && bus.o_rd_done), "done_both", 32'({bus.o_wr_done, bus.o_rd_done}), 0);
               check(done_q.size() != 0, "done_expected", 32'(done_q.size()), 1);
               if (done_q.size() != 0) begin
                  e = done_q.pop_front();
                  check(bus.o_wr_done == e, "done_dir", 32'(bus.o_wr_done), 32'(e));
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge i_clk);
      #2;
   endtask

   task automatic wait_idle(input int max_cycles, input string name);
      int n = 0;
      tick();
      while (!(phase == 0 && wq.size() == 0 && rq.size() == 0 && grant_q.size() == 0)
             && n < max_cycles) begin
         tick();
         n++;
      end
      check(n < max_cycles, name, 32'(n), 32'(max_cycles));
      tick();
   endtask

   task automatic check_quiet(input string name);
      check({bus.o_mem_req, bus.o_mem_we, bus.o_wr_pop, bus.o_wr_done, bus.o_rd_push,
             bus.o_rd_done, bus.o_busy} == 7'b0, name,
            32'({bus.o_mem_req, bus.o_mem_we, bus.o_wr_pop, bus.o_wr_done, bus.o_rd_push,
                 bus.o_rd_done, bus.o_busy}), 0);
      check(bus.o_mem_addr == '0, {name, "_addr"}, 32'(bus.o_mem_addr), 0);
   endtask

   initial begin
      int b_wp, b_rp, b_wd, b_rd, b_rq, b_seen;
      logic [7:0] pattern;
      pattern = 8'b0001_0001;   // R,R,R,W,R,R,R,W oldest first in bit 7
      bus.i_wr_req = 0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
      bus.i_rd_req = 0; bus.i_rd_addr = '0; bus.i_mem_ack = 0;
      bus.i_mem_wready = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;

      repeat (3) tick();
      check_quiet("reset_outputs");
      i_rst_n = 1'b1;
      drv_en = 1;
      tick();
      check_quiet("post_reset_idle");

      // lone write, immediate ack, wready every cycle
      b_wp = wr_pops; b_wd = wr_dones; b_rq = req_cycles;
      wq.push_back(23'h000100);
      wait_idle(200, "lone_write_timeout");
      check(wr_pops - b_wp == 8, "lone_write_pops", 32'(wr_pops - b_wp), 8);
      check(wr_dones - b_wd == 1, "lone_write_done", 32'(wr_dones - b_wd), 1);
      check(req_cycles - b_rq == 1, "lone_write_req_cycles", 32'(req_cycles - b_rq), 1);
      check(!bus.o_busy, "lone_write_idle", 32'(bus.o_busy), 0);

      // lone read with rvalid on alternate cycles
      alt = 1;
      b_rp = rd_pushes; b_rd = rd_dones;
      rq.push_back(23'h012C00);
      wait_idle(200, "lone_read_timeout");
      check(rd_pushes - b_rp == 8, "lone_read_pushes", 32'(rd_pushes - b_rp), 8);
      check(rd_dones - b_rd == 1, "lone_read_done", 32'(rd_dones - b_rd), 1);
      alt = 0;

      // command stall of 10 cycles with stray strobes around it
      ack_delay = 10; stray_pct = 50;
      b_wp = wr_pops; b_rq = req_cycles;
      wq.push_back(23'h3ABCDE);
      wait_idle(300, "stall_timeout");
      check(req_cycles - b_rq == 11, "stall_req_cycles", 32'(req_cycles - b_rq), 11);
      check(wr_pops - b_wp == 8, "stall_pops", 32'(wr_pops - b_wp), 8);

      // stray strobes in every non-data cycle, gappy data
      ack_delay = 1; stray_pct = 60; beat_pct = 50;
      b_wp = wr_pops; b_rp = rd_pushes;
      wq.push_back(23'h000200); rq.push_back(23'h000300);
      wait_idle(400, "stray_timeout");
      check(wr_pops - b_wp == 8, "stray_pops", 32'(wr_pops - b_wp), 8);
      check(rd_pushes - b_rp == 8, "stray_pushes", 32'(rd_pushes - b_rp), 8);

      // contention: both held high
      ack_delay = 0; stray_pct = 0; beat_pct = 100;
      b_seen = seen_we.size();
      for (int i = 0; i < 6; i++) begin
         wq.push_back(ADDR_W'(32'h1000 + i * 8));
         rq.push_back(ADDR_W'(32'h2000 + i * 8));
      end
      wait_idle(1000, "contention_timeout");
      for (int i = 0; i < 8; i++)
         if (b_seen + i < seen_we.size())
            check(seen_we[b_seen + i] == pattern[7 - i], "contention_order",
                  32'(seen_we[b_seen + i]), 32'(pattern[7 - i]));
      check(seen_we.size() - b_seen == 12, "contention_grants", 32'(seen_we.size() - b_seen), 12);

      // randomized traffic
      auto_ack = 1; garbage = 1; beat_pct = 70; stray_pct = 30; auto_left = 60;
      wait_idle(20000, "random_timeout");
      auto_ack = 0; garbage = 0; beat_pct = 100; stray_pct = 0; ack_delay = 0;
      drive_reqs();

      // reset in the middle of a write burst
      b_wp = wr_pops; b_wd = wr_dones; b_rp = rd_pushes;
      wq.push_back(23'h000400);
      for (int n = 0; n < 100 && wr_pops - b_wp < 4; n++) tick();
      check(wr_pops - b_wp == 4, "midburst_pops", 32'(wr_pops - b_wp), 4);
      i_rst_n = 1'b0;
      #1;
      check_quiet("midburst_reset");
      wq.delete(); grant_q.delete(); wdata_q.delete(); rdata_q.delete(); done_q.delete();
      phase = 0; model_skip = 0;
      bus.i_mem_wready = 0; bus.i_mem_rvalid = 0; bus.i_mem_ack = 0;
      tick();
      check_quiet("midburst_held");
      rq.push_back(23'h012C00);
      drive_reqs();
      tick();
      i_rst_n = 1'b1;
      tick();
      check(!bus.o_mem_req, "post_reset_gap", 32'(bus.o_mem_req), 0);
      tick();
      check(bus.o_mem_req, "post_reset_cmd", 32'(bus.o_mem_req), 1);
      check(bus.o_mem_addr == 23'h012C00, "post_reset_addr", 32'(bus.o_mem_addr), 32'h12C00);
      wait_idle(200, "post_reset_timeout");
      check(wr_dones == b_wd, "midburst_no_done", 32'(wr_dones - b_wd), 0);
      check(rd_pushes - b_rp == 8, "post_reset_pushes", 32'(rd_pushes - b_rp), 8);

      check(wdata_q.size() == 0, "left_wdata", 32'(wdata_q.size()), 0);
      check(rdata_q.size() == 0, "left_rdata", 32'(rdata_q.size()), 0);
      check(done_q.size() == 0, "left_done", 32'(done_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
